// File: rtl/wb_grf_pkg.sv
// Shared MIPS opcode/funct encodings and the writeback write-class decode.
// The decode and memory stages use the same definitions, so the encodings live here.
package wb_grf_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_JALR = 6'h09;
  localparam logic [5:0] F_MOVZ = 6'h0A;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  localparam logic [4:0] RA_LINK = 5'd31;

  typedef enum logic [2:0] {
    WC_NONE,
    WC_RD_ALU,
    WC_MOVZ,
    WC_RT_ALU,
    WC_LOAD,
    WC_JAL,
    WC_JALR
  } wclass_t;

  function automatic wclass_t decode_wclass(input logic [5:0] op, input logic [5:0] funct);
    wclass_t c;
    c = WC_NONE;
    case (op)
      OP_SPECIAL: begin
        case (funct)
          F_ADDU, F_SUBU, F_AND, F_OR, F_SLT, F_SLTU,
          F_SLL, F_SRL, F_SRA: c = WC_RD_ALU;
          F_MOVZ:              c = WC_MOVZ;
          F_JALR:              c = WC_JALR;
          default:             c = WC_NONE;
        endcase
      end
      OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_SLTI: c = WC_RT_ALU;
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW:                  c = WC_LOAD;
      OP_JAL:                                              c = WC_JAL;
      default:                                             c = WC_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/wb_grf_load_ext.sv
// Load data extraction: picks the addressed byte/half out of the aligned
// memory word (little-endian) and sign- or zero-extends it.
module load_ext
  import wb_grf_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [1:0]  addr,
  input  logic [31:0] dmW,
  output logic [31:0] ext
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_unused;

  assign w_unused = ^instr[25:0];

  always_comb begin
    w_byte = dmW[7:0];
    case (addr)
      2'd0: w_byte = dmW[7:0];
      2'd1: w_byte = dmW[15:8];
      2'd2: w_byte = dmW[23:16];
      2'd3: w_byte = dmW[31:24];
      default: w_byte = dmW[7:0];
    endcase
  end

  assign w_half = addr[1] ? dmW[31:16] : dmW[15:0];

  always_comb begin
    ext = dmW;
    case (instr[31:26])
      OP_LB:   ext = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  ext = {24'd0, w_byte};
      OP_LH:   ext = {{16{w_half[15]}}, w_half};
      OP_LHU:  ext = {16'd0, w_half};
      default: ext = dmW;
    endcase
  end

endmodule

// File: rtl/wb_grf.sv
// Writeback stage: decodes the W instruction into a register write and owns
// the general register file with two bypassed combinational read ports.
module wb_grf
  import wb_grf_pkg::*;
#(
  parameter int NREG      = 32,
  parameter bit ZERO_HARD = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instrW,
  input  logic        changeW,
  input  logic [31:0] aluW,
  input  logic [31:0] dmW,
  input  logic [31:0] pc8W,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  output logic        we_o,
  output logic [4:0]  wa_o,
  output logic [31:0] wd_o
);

  logic [31:0] r_regs [NREG];
  wclass_t     w_class;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [31:0] w_ext;
  logic        w_unused;

  assign w_rt     = instrW[20:16];
  assign w_rd     = instrW[15:11];
  assign w_unused = ^{instrW[25:21], instrW[10:6]};

  // An all-zero word decodes as sll $0 but must look like a pure bubble.
  assign w_class = (instrW == 32'd0) ? WC_NONE : decode_wclass(instrW[31:26], instrW[5:0]);

  load_ext u_load_ext (
    .instr (instrW),
    .addr  (aluW[1:0]),
    .dmW   (dmW),
    .ext   (w_ext)
  );

  always_comb begin
    wa_o = 5'd0;
    wd_o = 32'd0;
    case (w_class)
      WC_RD_ALU, WC_MOVZ: begin wa_o = w_rd;    wd_o = aluW;  end
      WC_RT_ALU:          begin wa_o = w_rt;    wd_o = aluW;  end
      WC_LOAD:            begin wa_o = w_rt;    wd_o = w_ext; end
      WC_JAL:             begin wa_o = RA_LINK; wd_o = pc8W;  end
      WC_JALR:            begin wa_o = w_rd;    wd_o = pc8W;  end
      default:            begin wa_o = 5'd0;    wd_o = 32'd0; end
    endcase
  end

  assign we_o = (w_class != WC_NONE) &&
                ((w_class != WC_MOVZ) || changeW) &&
                !(ZERO_HARD && (wa_o == 5'd0));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= 32'd0;
    end else if (we_o && (32'(wa_o) < NREG)) begin
      r_regs[wa_o] <= wd_o;
    end
  end

  // Same-cycle W->D bypass: a reader sees the value being committed this cycle.
  always_comb begin
    rd1 = 32'd0;
    if (ZERO_HARD && (ra1 == 5'd0))   rd1 = 32'd0;
    else if (we_o && (ra1 == wa_o))   rd1 = wd_o;
    else if (32'(ra1) < NREG)         rd1 = r_regs[ra1];
  end

  always_comb begin
    rd2 = 32'd0;
    if (ZERO_HARD && (ra2 == 5'd0))   rd2 = 32'd0;
    else if (we_o && (ra2 == wa_o))   rd2 = wd_o;
    else if (32'(ra2) < NREG)         rd2 = r_regs[ra2];
  end

endmodule

// File: tb/tb_wb_grf.sv
// Directed bench for wb_grf: expected values are queued when stimulus is
// driven and popped when the corresponding DUT output is sampled.
module tb_wb_grf;
  import wb_grf_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instrW;
  logic        changeW;
  logic [31:0] aluW;
  logic [31:0] dmW;
  logic [31:0] pc8W;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic        we_o;
  logic [4:0]  wa_o;
  logic [31:0] wd_o;

  int n_assert = 0;
  int n_fail   = 0;

  string       sb_tag [$];
  logic [31:0] sb_exp [$];

  logic [5:0]  ld_op   [8] = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_LH, OP_LW};
  logic [1:0]  ld_addr [8] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0};
  logic [31:0] ld_exp  [8] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01,
                               32'h00000001, 32'h0000007F, 32'h00007F01, 32'h80FF7F01};

  wb_grf dut (
    .clk     (clk),
    .rst     (rst),
    .instrW  (instrW),
    .changeW (changeW),
    .aluW    (aluW),
    .dmW     (dmW),
    .pc8W    (pc8W),
    .ra1     (ra1),
    .ra2     (ra2),
    .rd1     (rd1),
    .rd2     (rd2),
    .we_o    (we_o),
    .wa_o    (wa_o),
    .wd_o    (wd_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] r_ins(input logic [5:0] funct, input logic [4:0] rd);
    return {OP_SPECIAL, 5'd1, 5'd2, rd, 5'd0, funct};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rt);
    return {op, 5'd3, rt, 16'h0010};
  endfunction

  task automatic push(input string tag, input logic [31:0] e);
    sb_tag.push_back(tag);
    sb_exp.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    string       tag;
    logic [31:0] e;
    n_assert++;
    if (sb_exp.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %h, nothing expected", obs);
    end else begin
      tag = sb_tag.pop_front();
      e   = sb_exp.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; instrW = 32'd0; changeW = 1'b0; aluW = 32'd0;
    dmW = 32'd0; pc8W = 32'd0; ra1 = 5'd0; ra2 = 5'd0;
    tick(); tick();
    rst = 1'b0;

    // preload r5, then reset clears it
    instrW = i_ins(OP_ADDIU, 5'd5); aluW = 32'h1234;
    push("preload_r5", 32'h1234);
    tick();
    instrW = 32'd0; ra1 = 5'd5; #1;
    check(rd1);
    push("reset_r5", 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    check(rd1);

    // R-type with both ports bypassing
    instrW = r_ins(F_ADDU, 5'd8); aluW = 32'hDEADBEEF; ra1 = 5'd8; ra2 = 5'd8;
    push("addu_we", 32'd1); push("addu_wa", 32'd8);
    push("addu_byp1", 32'hDEADBEEF); push("addu_byp2", 32'hDEADBEEF);
    #1;
    check({31'd0, we_o}); check({27'd0, wa_o}); check(rd1); check(rd2);
    push("addu_r8", 32'hDEADBEEF);
    tick();
    instrW = 32'd0; #1;
    check(rd1);

    // loads into r10
    dmW = 32'h80FF7F01;
    for (int i = 0; i < 8; i++) begin
      instrW = i_ins(ld_op[i], 5'd10);
      aluW   = {30'h00001000, ld_addr[i]};
      push($sformatf("load%0d_wd", i), ld_exp[i]);
      #1;
      check(wd_o);
      if (i == 0) begin
        push("load_we", 32'd1); push("load_wa", 32'd10);
        check({31'd0, we_o}); check({27'd0, wa_o});
      end
      tick();
    end
    instrW = 32'd0; ra2 = 5'd10;
    push("lw_r10", 32'h80FF7F01);
    #1;
    check(rd2);

    // jal / jalr
    instrW = {OP_JAL, 26'h0000400}; pc8W = 32'h3008; ra1 = 5'd0;
    push("jal_we", 32'd1); push("jal_wa", 32'd31); push("jal_wd", 32'h3008);
    #1;
    check({31'd0, we_o}); check({27'd0, wa_o}); check(wd_o);
    push("jal_r31", 32'h3008);
    tick();
    instrW = 32'd0; ra1 = 5'd31; #1;
    check(rd1);
    instrW = r_ins(F_JALR, 5'd4);
    push("jalr_r4", 32'h3008);
    tick();
    instrW = 32'd0; ra1 = 5'd4; #1;
    check(rd1);

    // movz gated by changeW
    instrW = r_ins(F_MOVZ, 5'd9); aluW = 32'd7; changeW = 1'b0;
    push("movz0_we", 32'd0);
    #1;
    check({31'd0, we_o});
    push("movz0_r9", 32'd0);
    tick();
    instrW = 32'd0; ra1 = 5'd9; #1;
    check(rd1);
    instrW = r_ins(F_MOVZ, 5'd9); changeW = 1'b1;
    push("movz1_we", 32'd1);
    #1;
    check({31'd0, we_o});
    push("movz1_r9", 32'd7);
    tick();
    instrW = 32'd0; changeW = 1'b0; #1;
    check(rd1);

    // $0 is hardwired
    instrW = i_ins(OP_ORI, 5'd0); aluW = 32'd5; ra1 = 5'd0;
    push("ori0_we", 32'd0); push("ori0_rd1", 32'd0);
    #1;
    check({31'd0, we_o}); check(rd1);
    push("r0_after", 32'd0);
    tick();
    instrW = 32'd0; #1;
    check(rd1);

    // bubbles and non-writing opcodes
    instrW = 32'd0; aluW = 32'h99;
    push("nop_we", 32'd0); push("nop_wa", 32'd0); push("nop_wd", 32'd0);
    #1;
    check({31'd0, we_o}); check({27'd0, wa_o}); check(wd_o);
    instrW = {6'h2B, 5'd3, 5'd7, 16'h0};
    push("sw_we", 32'd0); push("sw_wd", 32'd0);
    #1;
    check({31'd0, we_o}); check(wd_o);

    // independent ports while another register is written
    instrW = r_ins(F_OR, 5'd4); aluW = 32'hAAAA; ra1 = 5'd8; ra2 = 5'd10;
    push("nobyp_rd1", 32'hDEADBEEF); push("nobyp_rd2", 32'h80FF7F01);
    #1;
    check(rd1); check(rd2);
    ra1 = 5'd4;
    push("or_byp_r4", 32'hAAAA);
    #1;
    check(rd1);
    tick();

    // write coinciding with reset is lost
    instrW = r_ins(F_ADDU, 5'd12); aluW = 32'h55; rst = 1'b1;
    push("rst_write_r12", 32'd0);
    tick();
    rst = 1'b0; instrW = 32'd0; ra1 = 5'd12; #1;
    check(rd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
